// File: rtl/serial_frame_checker_pkg.sv
// serial_frame_pkg: shared definitions for the serial frame checker.
//   - frame geometry (SYNC_LEN, PAYLOAD_LEN) and the default sync header
//   - FSM state encodings and the state enum built on them
// Optional build macro used by importers: FRAME_PARITY_EN.
package serial_frame_pkg;

  localparam int unsigned SYNC_LEN    = 8;
  localparam int unsigned PAYLOAD_LEN = 32;

  localparam logic [SYNC_LEN-1:0] SYNC_WORD_DEF = 8'hA5;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_SYNC    = 2'd2;
  localparam logic [1:0] ST_PARITY  = 2'd3;

  typedef enum logic [1:0] {
    HUNT    = ST_HUNT,
    PAYLOAD = ST_PAYLOAD,
    SYNC    = ST_SYNC,
    PARITY  = ST_PARITY
  } state_e;

endpackage

// File: rtl/serial_frame_checker_if.sv
// serial_frame_checker_if: bit-stream input and frame-status output bundle.
//   en         bit strobe (data_in sampled only when 1)
//   data_in    serial frame stream, MSB first
//   clr_err    synchronous clear of err_cnt
//   word_out   last accepted payload
//   word_valid one-cycle pulse when word_out updates
//   locked     frame lock status
//   err_cnt    saturating framing/parity error count (ERR_W bits)
// master modport: stream source / status consumer. slave modport: the checker.
interface serial_frame_checker_if #(
  parameter int unsigned ERR_W = 16
);
  import serial_frame_pkg::*;

  logic                   en;
  logic                   data_in;
  logic                   clr_err;
  logic [PAYLOAD_LEN-1:0] word_out;
  logic                   word_valid;
  logic                   locked;
  logic [ERR_W-1:0]       err_cnt;

  modport master (
    output en, data_in, clr_err,
    input  word_out, word_valid, locked, err_cnt
  );

  modport slave (
    input  en, data_in, clr_err,
    output word_out, word_valid, locked, err_cnt
  );

endinterface

// File: rtl/serial_frame_checker_err_counter.sv
// frame_err_counter: ERR_W-bit saturating up-counter.
//   clk, rst_n  clock, asynchronous active-low reset
//   inc_i       count one error this cycle
//   clr_i       synchronous clear; wins over inc_i
//   cnt_o       current count, sticks at all-ones
module frame_err_counter #(
  parameter int unsigned ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [ERR_W-1:0] cnt_o
);

  logic [ERR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/serial_frame_checker.sv
// serial_frame_checker: hunts for the sync header in a 1-bit stream,
// deserializes the 32-bit payload behind it, keeps lock with a flywheel and
// counts framing errors.
//   clk    divided link clock
//   rst_n  asynchronous active-low reset
//   bus    serial_frame_checker_if.slave (en, data_in, clr_err in;
//          word_out, word_valid, locked, err_cnt out)
// Build macro FRAME_PARITY_EN: appends an even-parity bit to every frame and
// only delivers words whose parity checks.
module serial_frame_checker
  import serial_frame_pkg::*;
#(
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int unsigned         LOCK_CNT  = 3,
  parameter int unsigned         LOSS_CNT  = 2,
  parameter int unsigned         ERR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_frame_checker_if.slave bus
);

  // With parity the full payload must survive one extra bit time, otherwise
  // the last payload bit comes straight from data_in.
`ifdef FRAME_PARITY_EN
  localparam int unsigned SR_W = PAYLOAD_LEN;
`else
  localparam int unsigned SR_W = PAYLOAD_LEN - 1;
`endif
  localparam logic [3:0] LOCK_C    = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_C    = 4'(LOSS_CNT);
  localparam logic [4:0] PAY_LAST  = 5'(PAYLOAD_LEN - 1);
  localparam logic [4:0] SYNC_LAST = 5'(SYNC_LEN - 1);

  state_e                 state_q, state_d;
  logic [SR_W-1:0]        shift_q, shift_d;
  logic [SR_W:0]          shift_in;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [3:0]             good_q, good_d;
  logic [3:0]             bad_q, bad_d;
  logic                   locked_q, locked_d;
  logic [PAYLOAD_LEN-1:0] word_q, word_d, payload;
  logic [ERR_W-1:0]       err_cnt;
  logic                   sync_hit, deliver, err_inc;

  assign shift_in = {shift_q, bus.data_in};
  assign sync_hit = (shift_in[SYNC_LEN-1:0] == SYNC_WORD);
`ifdef FRAME_PARITY_EN
  assign payload  = shift_q;
`else
  assign payload  = shift_in;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    good_d    = good_q;
    bad_d     = bad_q;
    locked_d  = locked_q;
    deliver   = 1'b0;
    err_inc   = 1'b0;
    if (bus.en) begin
      shift_d   = shift_in[SR_W-1:0];
      bit_cnt_d = bit_cnt_q + 5'd1;
      case (state_q)
        HUNT: begin
          if (sync_hit) begin
            good_d    = 4'd1;
            bad_d     = '0;  // stale loss count must not carry into a new lock
            bit_cnt_d = '0;
            state_d   = PAYLOAD;
            if (LOCK_C == 4'd1) locked_d = 1'b1;
          end
        end
        PAYLOAD: begin
          if (bit_cnt_q == PAY_LAST) begin
            bit_cnt_d = '0;
`ifdef FRAME_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = SYNC;
            deliver   = locked_q;
`endif
          end
        end
`ifdef FRAME_PARITY_EN
        PARITY: begin
          bit_cnt_d = '0;
          state_d   = SYNC;
          if (locked_q) begin
            // even parity: payload plus parity bit carry an even number of ones
            deliver = ~(^shift_in);
            err_inc = ^shift_in;
          end
        end
`endif
        SYNC: begin
          if (bit_cnt_q == SYNC_LAST) begin
            bit_cnt_d = '0;
            if (sync_hit) begin
              bad_d   = '0;
              state_d = PAYLOAD;
              if (good_q >= LOCK_C - 4'd1) begin
                good_d   = LOCK_C;
                locked_d = 1'b1;
              end else begin
                good_d = good_q + 4'd1;
              end
            end else if (locked_q) begin
              err_inc = 1'b1;
              good_d  = '0;
              if (bad_q >= LOSS_C - 4'd1) begin
                bad_d    = '0;
                locked_d = 1'b0;
                state_d  = HUNT;
              end else begin
                bad_d   = bad_q + 4'd1;
                state_d = PAYLOAD;  // flywheel: trust the frame timing once more
              end
            end else begin
              good_d  = '0;
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    word_d = deliver ? payload : word_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      locked_q  <= 1'b0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      locked_q  <= locked_d;
      word_q    <= word_d;
    end
  end

  frame_err_counter #(
    .ERR_W(ERR_W)
  ) u_err_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(err_inc),
    .clr_i(bus.clr_err),
    .cnt_o(err_cnt)
  );

  // The word is presented in the same cycle its last bit is sampled.
  assign bus.word_valid = deliver;
  assign bus.word_out   = word_d;
  assign bus.locked     = locked_q;
  assign bus.err_cnt    = err_cnt;

endmodule
